status_keys: RTL and testbench

- Input-side companion to the status LED driver: reads the board push-buttons and turns them into clean, debounced, single-cycle key events for the control logic.
- Per key:
  - 2-FF synchroniser
  - debounce state machine
  - hold timer that separates short clicks from long presses
- Sits beside the status LED block on the same clk; its events drive mode changes that the LEDs then display.

---
 rtl/status_keys_if.sv | 26 ++
 rtl/status_keys.sv | 192 +++++++++++++++++++
 tb/tb_status_keys.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/status_keys_if.sv
// Key event bus for status_keys: raw button pins in, debounced levels and
// single-cycle key events out. The master side is the key block itself, the
// slave side is whoever owns the pins and consumes the events.
// "release" and "repeat" are SystemVerilog keywords, so those two event
// lines are called release_evt and repeat_evt.
interface status_keys_if #(
    parameter int KEYS = 2
);
    logic [KEYS-1:0] key_pin;
    logic [KEYS-1:0] down;
    logic [KEYS-1:0] press;
    logic [KEYS-1:0] release_evt;
    logic [KEYS-1:0] click;
    logic [KEYS-1:0] long_press;
    logic [KEYS-1:0] repeat_evt;

    modport master (
        input  key_pin,
        output down, press, release_evt, click, long_press, repeat_evt
    );

    modport slave (
        output key_pin,
        input  down, press, release_evt, click, long_press, repeat_evt
    );
endinterface

// File: rtl/status_keys.sv
// status_keys: per-key 2-FF synchroniser, debounce FSM and hold timer that
// turns raw push-button pins into debounced levels and one-cycle events
// (press, release, click, long_press, optional auto-repeat).
// Optional feature: define STATUS_KEYS_REPEAT_EN to build the auto-repeat
// counter; without it repeat_evt is tied to 0 and no counter exists.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// RELEASED     | key idle, down=0
// PRESS_WAIT   | pin active, counting stable cycles before accepting press
// HELD         | press accepted, hold timer running toward long press
// LONG_HELD    | long press reached, hold timer stopped
// RELEASE_WAIT | pin inactive while held, counting stable cycles (down=1)
module status_keys #(
    parameter int KEYS            = 2,
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 270_000,
    parameter int LONG_CYCLES     = 27_000_000,
    parameter int REPEAT_CYCLES   = 5_000_000
) (
    input logic          clk,
    input logic          reset,
    status_keys_if.master bus
);

    localparam int MAX_DL     = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
    localparam int MAX_CYCLES = (MAX_DL > REPEAT_CYCLES) ? MAX_DL : REPEAT_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES);

    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]   DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]   LONG_LAST = CW'(LONG_CYCLES - 1);
    localparam logic [KEYS-1:0] IDLE_PIN  = {KEYS{ACTIVE_LOW != 0}};

    typedef enum logic [2:0] {
        RELEASED,
        PRESS_WAIT,
        HELD,
        LONG_HELD,
        RELEASE_WAIT
    } state_t;

    logic [KEYS-1:0] sync1;
    logic [KEYS-1:0] sync2;
    logic [KEYS-1:0] act;

    state_t          state [KEYS];
    logic [CW-1:0]   dcnt  [KEYS];
    logic [CW-1:0]   hcnt  [KEYS];
    logic [KEYS-1:0] long_flag;

    logic [KEYS-1:0] down_q;
    logic [KEYS-1:0] press_q;
    logic [KEYS-1:0] release_q;
    logic [KEYS-1:0] click_q;
    logic [KEYS-1:0] long_q;

`ifdef STATUS_KEYS_REPEAT_EN
    localparam logic [CW-1:0] RPT_LAST = CW'(REPEAT_CYCLES - 1);

    logic [CW-1:0]   rcnt [KEYS];
    logic [KEYS-1:0] repeat_q;
`endif

    // Two-flop synchroniser; resets to the idle pin level so a pressed key
    // during reset looks like a fresh press afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= IDLE_PIN;
            sync2 <= IDLE_PIN;
        end else begin
            sync1 <= bus.key_pin;
            sync2 <= sync1;
        end
    end

    assign act = sync2 ^ IDLE_PIN;

    // Per-key debounce/hold FSM with registered level and event outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < KEYS; k++) begin
                state[k] <= RELEASED;
                dcnt[k]  <= '0;
                hcnt[k]  <= '0;
`ifdef STATUS_KEYS_REPEAT_EN
                rcnt[k]  <= '0;
`endif
            end
            long_flag <= '0;
            down_q    <= '0;
            press_q   <= '0;
            release_q <= '0;
            click_q   <= '0;
            long_q    <= '0;
`ifdef STATUS_KEYS_REPEAT_EN
            repeat_q  <= '0;
`endif
        end else begin
            for (int k = 0; k < KEYS; k++) begin
                press_q[k]   <= 1'b0;
                release_q[k] <= 1'b0;
                click_q[k]   <= 1'b0;
                long_q[k]    <= 1'b0;
`ifdef STATUS_KEYS_REPEAT_EN
                repeat_q[k]  <= 1'b0;
`endif
                case (state[k])
                    RELEASED: begin
                        if (act[k]) begin
                            state[k] <= PRESS_WAIT;
                            dcnt[k]  <= '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!act[k]) begin
                            state[k] <= RELEASED;
                        end else if (dcnt[k] == DEB_LAST) begin
                            state[k]     <= HELD;
                            press_q[k]   <= 1'b1;
                            down_q[k]    <= 1'b1;
                            hcnt[k]      <= '0;
                            long_flag[k] <= 1'b0;
                        end else begin
                            dcnt[k] <= dcnt[k] + CNT_ONE;
                        end
                    end
                    HELD: begin
                        if (!act[k]) begin
                            state[k] <= RELEASE_WAIT;
                            dcnt[k]  <= '0;
                        end else if (hcnt[k] == LONG_LAST) begin
                            state[k]     <= LONG_HELD;
                            long_q[k]    <= 1'b1;
                            long_flag[k] <= 1'b1;
`ifdef STATUS_KEYS_REPEAT_EN
                            rcnt[k]      <= '0;
`endif
                        end else begin
                            hcnt[k] <= hcnt[k] + CNT_ONE;
                        end
                    end
                    LONG_HELD: begin
                        if (!act[k]) begin
                            state[k] <= RELEASE_WAIT;
                            dcnt[k]  <= '0;
                        end
`ifdef STATUS_KEYS_REPEAT_EN
                        else if (rcnt[k] == RPT_LAST) begin
                            repeat_q[k] <= 1'b1;
                            rcnt[k]     <= '0;
                        end else begin
                            rcnt[k] <= rcnt[k] + CNT_ONE;
                        end
`endif
                    end
                    RELEASE_WAIT: begin
                        // hcnt and the repeat counter stay frozen here so a
                        // bounce resumes the hold where it left off.
                        if (act[k]) begin
                            state[k] <= long_flag[k] ? LONG_HELD : HELD;
                        end else if (dcnt[k] == DEB_LAST) begin
                            state[k]     <= RELEASED;
                            release_q[k] <= 1'b1;
                            click_q[k]   <= ~long_flag[k];
                            down_q[k]    <= 1'b0;
                        end else begin
                            dcnt[k] <= dcnt[k] + CNT_ONE;
                        end
                    end
                    default: begin
                        state[k]  <= RELEASED;
                        down_q[k] <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.down        = down_q;
    assign bus.press       = press_q;
    assign bus.release_evt = release_q;
    assign bus.click       = click_q;
    assign bus.long_press  = long_q;

`ifdef STATUS_KEYS_REPEAT_EN
    assign bus.repeat_evt = repeat_q;
`else
    assign bus.repeat_evt = '0;
`endif

endmodule

// File: tb/tb_status_keys.sv
// Testbench for status_keys: directed sequences from the key scenarios
// followed by randomized per-key press/release/bounce traffic and random
// resets, all compared cycle by cycle against a run-length reference model.
module tb_status_keys;

    localparam int KEYS = 2;
    localparam int DEB  = 4;
    localparam int LNG  = 20;
    localparam int RPT  = 6;

    logic            clk   = 1'b0;
    logic            reset = 1'b0;
    logic [KEYS-1:0] pins  = '0;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    status_keys_if #(.KEYS(KEYS)) bus ();

    assign bus.key_pin = pins;

    status_keys #(
        .KEYS            (KEYS),
        .ACTIVE_LOW      (1),
        .DEBOUNCE_CYCLES (DEB),
        .LONG_CYCLES     (LNG),
        .REPEAT_CYCLES   (RPT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    // Reference model: a key is accepted as changed once the synchronised
    // level has differed from the accepted level for DEB+1 consecutive
    // samples; hold time counts uninterrupted pressed samples after press.
    logic [KEYS-1:0] s1, s2;
    logic [KEYS-1:0] m_down, m_press, m_rel, m_click, m_long, m_rpt;
    logic [KEYS-1:0] lng;
    int run  [KEYS];
    int hold [KEYS];
    int rc   [KEYS];

    task automatic chk(input string tag, input logic [KEYS-1:0] got, input logic [KEYS-1:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        s1 = '1;
        s2 = '1;
        m_down = '0; m_press = '0; m_rel = '0;
        m_click = '0; m_long = '0; m_rpt = '0;
        lng = '0;
        for (int k = 0; k < KEYS; k++) begin
            run[k] = 0; hold[k] = 0; rc[k] = 0;
        end
    endtask

    task automatic model_edge();
        logic [KEYS-1:0] a;
        if (!reset) begin
            model_reset();
            return;
        end
        a  = ~s2;
        s2 = s1;
        s1 = pins;
        m_press = '0; m_rel = '0; m_click = '0; m_long = '0; m_rpt = '0;
        for (int k = 0; k < KEYS; k++) begin
            if (!m_down[k]) begin
                if (a[k]) begin
                    run[k]++;
                    if (run[k] == DEB + 1) begin
                        m_press[k] = 1'b1;
                        m_down[k]  = 1'b1;
                        run[k]     = 0;
                        hold[k]    = 0;
                        lng[k]     = 1'b0;
                    end
                end else begin
                    run[k] = 0;
                end
            end else if (!a[k]) begin
                run[k]++;
                if (run[k] == DEB + 1) begin
                    m_rel[k]   = 1'b1;
                    m_click[k] = ~lng[k];
                    m_down[k]  = 1'b0;
                    run[k]     = 0;
                end
            end else begin
                if (run[k] == 0) begin
                    if (!lng[k]) begin
                        hold[k]++;
                        if (hold[k] == LNG) begin
                            m_long[k] = 1'b1;
                            lng[k]    = 1'b1;
                            rc[k]     = 0;
                        end
                    end else begin
`ifdef STATUS_KEYS_REPEAT_EN
                        rc[k]++;
                        if (rc[k] == RPT) begin
                            m_rpt[k] = 1'b1;
                            rc[k]    = 0;
                        end
`endif
                    end
                end
                run[k] = 0;
            end
        end
    endtask

    task automatic check_outputs();
        chk("down",       bus.down,        m_down);
        chk("press",      bus.press,       m_press);
        chk("release",    bus.release_evt, m_rel);
        chk("click",      bus.click,       m_click);
        chk("long_press", bus.long_press,  m_long);
        chk("repeat",     bus.repeat_evt,  m_rpt);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run_pins(input logic [KEYS-1:0] p, input int n);
        pins = p;
        repeat (n) cycle();
    endtask

    // Called just after a negedge; reset must clear down immediately.
    task automatic pulse_reset(input int n);
        reset = 1'b0;
        #1;
        model_reset();
        chk("rst_down_now", bus.down, '0);
        repeat (n) cycle();
        reset = 1'b1;
    endtask

    int left [KEYS];

    initial begin
        model_reset();
        pins  = 2'b00;
        reset = 1'b0;
        repeat (3) cycle();
        reset = 1'b1;

        // Both pressed through reset, then released.
        run_pins(2'b00, 12);
        run_pins(2'b11, 12);
        // Clean click on key 0.
        run_pins(2'b10, 12);
        run_pins(2'b11, 12);
        // Glitch rejected.
        run_pins(2'b10, 3);
        run_pins(2'b11, 8);
        // Release bounce inside a hold.
        run_pins(2'b10, 10);
        run_pins(2'b11, 2);
        run_pins(2'b10, 6);
        run_pins(2'b11, 12);
        // Long press on key 1.
        run_pins(2'b01, 40);
        run_pins(2'b11, 12);
        // Reset mid-hold, pin kept pressed.
        run_pins(2'b10, 10);
        pulse_reset(2);
        run_pins(2'b10, 12);
        run_pins(2'b11, 12);

        // Randomized traffic: mixed glitches, short clicks and long holds.
        for (int k = 0; k < KEYS; k++) left[k] = 0;
        for (int n = 0; n < 4000; n++) begin
            for (int k = 0; k < KEYS; k++) begin
                if (left[k] == 0) begin
                    pins[k] = ~pins[k];
                    case ($urandom_range(0, 3))
                        0:       left[k] = $urandom_range(1, 3);
                        1:       left[k] = $urandom_range(5, 12);
                        2:       left[k] = $urandom_range(22, 45);
                        default: left[k] = $urandom_range(2, 6);
                    endcase
                end
                left[k]--;
            end
            if ($urandom_range(0, 699) == 0) begin
                pulse_reset($urandom_range(1, 3));
            end else begin
                cycle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
